aclint_memory: RTL and testbench
================================

// Module: aclint_memory
//
// PURPOSE
// Memory-mapped ACLINT (MSWI + MTIMER) for hart 0. Sits on the data-memory bus
// behind the address decoder. Holds mtime, mtimecmp and msip, and drives the
// aclint_if master side (mtime, mtip, msip) into the CSR unit's mip/time logic.
// Single-outstanding request/response slave with a fixed 1-cycle response.
//
// PARAMETERS
// PRESCALE  1  core clocks per mtime tick (>=1); 1 = increment every cycle
//
// PORTS
// clk          in   1   core clock
// rst          in   1   async reset, active low
// req_valid    in   1   bus request valid
// req_ready    out  1   slave accepts request this cycle
// req_addr     in   16  byte offset within ACLINT window; [2:0] ignored
// req_wen      in   1   1 = write, 0 = read
// req_wdata    in   64  write data, doubleword-aligned lanes
// req_wmask    in   8   byte enables for writes
// resp_valid   out  1   response valid (read data or write ack)
// resp_rdata   out  64  read data; 0 for writes and unmapped
// aclint       aclint_if.master  mtime[63:0], mtip, msip
//
// BEHAVIOUR
// Register map (doubleword index = req_addr[15:3]):
// - 0x0000: MSIP. Bit 0 = msip; bits [31:1] read 0. Upper word [63:32] reads 0.
// - 0x4000: MTIMECMP (64b RW).
// - 0xBFF8: MTIME (64b RW).
// - Other offsets: read 0, write ignored, still acknowledged.
//
// Reset values:
// - mtime = 0, mtimecmp = all-ones, msip = 0, prescale count = 0.
// - resp_valid = 0, resp_rdata = 0.
//
// Handshake:
// - req_ready = !resp_valid, so requests are accepted only on alternate cycles at most.
// - Request accepted at edge N: resp_valid = 1 for exactly the cycle after N.
// - No response backpressure.
// - A read returns register contents as of before edge N. It does not include an mtime
//   tick at N.
//
// Writes:
// - New value = (old & ~m) | (wdata & m), where m is req_wmask expanded bytewise.
// - MSIP: only byte-lane 0 bit 0 is significant.
//
// mtime:
// - The prescale counter runs 0..PRESCALE-1.
// - mtime increments by 1 on the edge where count == PRESCALE-1, then count returns to 0.
// - Wrap: 2^64-1 + 1 -> 0. No flag is raised.
// - A write to MTIME at the same edge as a tick: the write wins, the tick is dropped,
//   and count is cleared to 0.
// - Partial-mask MTIME write: masked merge against the pre-tick value.
//
// Outputs to aclint_if:
// - mtip = (mtime >= mtimecmp), unsigned 64-bit, combinational from registers.
//   It is valid in the cycle after any change to mtime or mtimecmp. It stays asserted
//   until mtimecmp > mtime or mtime wraps.
// - msip = msip register; aclint.mtime = mtime register. There is no extra latency.
//
// Reset mid-operation:
// - All state returns to reset values asynchronously.
// - An in-flight response is dropped; resp_valid = 0.
//
// TESTING
// - Reset, PRESCALE=1, idle 10 cycles -> read 0xBFF8 returns 10 (±0 per read-timing rule);
//   mtip=0.
// - Write MTIMECMP=0x20 mask 0xFF at mtime<0x20 -> mtip rises the cycle mtime reaches 0x20;
//   then write MTIMECMP=0xFFFF_FFFF_FFFF_FFFF -> mtip=0 next cycle.
// - Write MSIP data 0xFFFF_FFFF_FFFF_FFFF mask 0x01 -> msip=1, read 0x0000 returns 1;
//   write 0 -> msip=0.
// - Write MTIME=0xFFFF_FFFF_FFFF_FFFE, wait 2 ticks -> mtime=0; with mtimecmp=0x10,
//   mtip drops from 1 to 0 at wrap.
// - PRESCALE=4: MTIME write coinciding with tick edge -> mtime=written value,
//   next increment exactly 4 cycles later.
// - Back-to-back req_valid -> req_ready toggles 1/0; read of 0x1234 returns 0 and
//   write to it changes nothing; assert rst mid-response -> resp_valid=0 immediately.

Source files
------------

// File: rtl/aclint_memory_if.sv
// Timer/software-interrupt signals from the ACLINT to the CSR unit's mip/time logic.
interface aclint_if;
    logic [63:0] mtime;
    logic        mtip;
    logic        msip;

    modport master (output mtime, output mtip, output msip);
    modport slave  (input  mtime, input  mtip, input  msip);
endinterface

// File: rtl/aclint_memory.sv
// Memory-mapped ACLINT (MSWI + MTIMER) for hart 0.
// Holds msip, mtimecmp and mtime behind a single-outstanding bus slave that
// answers every accepted request exactly one cycle later.
module aclint_memory #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    aclint_if.master    aclint
);

    localparam int unsigned    CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    // Doubleword indices (byte offset >> 3) of the mapped registers.
    localparam logic [12:0] IDX_MSIP     = 13'h0000;
    localparam logic [12:0] IDX_MTIMECMP = 13'h0800;
    localparam logic [12:0] IDX_MTIME    = 13'h17FF;

    logic [63:0]      mtime;
    logic [63:0]      mtimecmp;
    logic             msip;
    logic [CNT_W-1:0] count;

    logic [12:0] idx;
    logic        accept;
    logic        wr;
    logic        tick;
    logic        mtime_wr;
    logic        mtimecmp_wr;
    logic        msip_wr;
    logic [63:0] wmask_bits;
    logic [63:0] read_data;
    logic [2:0]  unused_addr_lsbs;

    // The low address bits only select bytes inside a doubleword; lanes come from the mask.
    assign unused_addr_lsbs = req_addr[2:0];

    assign idx         = req_addr[15:3];
    assign req_ready   = !resp_valid;
    assign accept      = req_valid && req_ready;
    assign wr          = accept && req_wen;
    assign tick        = (count == CNT_LAST);
    assign mtime_wr    = wr && (idx == IDX_MTIME);
    assign mtimecmp_wr = wr && (idx == IDX_MTIMECMP);
    assign msip_wr     = wr && (idx == IDX_MSIP) && req_wmask[0];

    // Expand the byte enables into a per-bit merge mask.
    always_comb begin
        wmask_bits = '0;
        for (int b = 0; b < 8; b++) begin
            wmask_bits[b*8 +: 8] = {8{req_wmask[b]}};
        end
    end

    // Read mux over the register contents as they stand before the accepting edge.
    always_comb begin
        read_data = '0;
        case (idx)
            IDX_MSIP:     read_data = {63'd0, msip};
            IDX_MTIMECMP: read_data = mtimecmp;
            IDX_MTIME:    read_data = mtime;
            default:      read_data = '0;
        endcase
    end

    // Prescale counter; a bus write to mtime restarts the tick period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (mtime_wr || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // mtime: a bus write takes priority over (and swallows) a coincident tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime <= '0;
        end else if (mtime_wr) begin
            mtime <= (mtime & ~wmask_bits) | (req_wdata & wmask_bits);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // mtimecmp resets to all-ones so no timer interrupt is pending out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtimecmp <= '1;
        end else if (mtimecmp_wr) begin
            mtimecmp <= (mtimecmp & ~wmask_bits) | (req_wdata & wmask_bits);
        end
    end

    // msip holds only bit 0 of byte lane 0; all other bits are hardwired zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msip <= 1'b0;
        end else if (msip_wr) begin
            msip <= req_wdata[0];
        end
    end

    // Fixed one-cycle response; writes and unmapped offsets return zero data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= accept;
            resp_rdata <= (accept && !req_wen) ? read_data : 64'd0;
        end
    end

    assign aclint.mtime = mtime;
    assign aclint.msip  = msip;
    assign aclint.mtip  = (mtime >= mtimecmp);

endmodule

// File: tb/tb_aclint_memory.sv
// Directed testbench for aclint_memory: one instance with PRESCALE=1 for the
// map/handshake/compare checks and one with PRESCALE=4 for tick alignment.
module tb_aclint_memory;

    logic        clk;
    logic        rst;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [15:0] req_addr   [2];
    logic        req_wen    [2];
    logic [63:0] req_wdata  [2];
    logic [7:0]  req_wmask  [2];
    logic        resp_valid [2];
    logic [63:0] resp_rdata [2];

    int errors = 0;
    int checks = 0;

    aclint_if acl0 ();
    aclint_if acl1 ();

    aclint_memory #(.PRESCALE(1)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_addr   (req_addr[0]),
        .req_wen    (req_wen[0]),
        .req_wdata  (req_wdata[0]),
        .req_wmask  (req_wmask[0]),
        .resp_valid (resp_valid[0]),
        .resp_rdata (resp_rdata[0]),
        .aclint     (acl0)
    );

    aclint_memory #(.PRESCALE(4)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_addr   (req_addr[1]),
        .req_wen    (req_wen[1]),
        .req_wdata  (req_wdata[1]),
        .req_wmask  (req_wmask[1]),
        .resp_valid (resp_valid[1]),
        .resp_rdata (resp_rdata[1]),
        .aclint     (acl1)
    );

    // 10 ns core clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // One bus transaction; called just after a rising edge, returns just after the response edge.
    task automatic applyStimulus(input int d, input logic [15:0] addr, input logic wen,
                                 input logic [63:0] wdata, input logic [7:0] wmask,
                                 output logic [63:0] rdata);
        if (!req_ready[d]) stepCycle();
        if (!req_ready[d]) checkOutput("ready_timeout", 64'(req_ready[d]), 64'd1);
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        req_wen[d]   = wen;
        req_wdata[d] = wdata;
        req_wmask[d] = wmask;
        stepCycle();
        req_valid[d] = 1'b0;
        checkOutput("resp_valid", 64'(resp_valid[d]), 64'd1);
        rdata = resp_rdata[d];
        if (wen) checkOutput("wr_rdata", rdata, 64'd0);
    endtask

    initial begin
        logic [63:0] r;
        logic [63:0] prev;
        int          n;

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_addr[d]  = '0;
            req_wen[d]   = 1'b0;
            req_wdata[d] = '0;
            req_wmask[d] = '0;
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_resp_valid", 64'(resp_valid[0]), 64'd0);
        checkOutput("rst_resp_rdata", resp_rdata[0], 64'd0);
        checkOutput("rst_req_ready", 64'(req_ready[0]), 64'd1);
        checkOutput("rst_mtime", acl0.mtime, 64'd0);
        checkOutput("rst_mtip", 64'(acl0.mtip), 64'd0);
        checkOutput("rst_msip", 64'(acl0.msip), 64'd0);
        checkOutput("rst_mtime1", acl1.mtime, 64'd0);
        rst = 1'b1;

        // Free-running count, then a read that excludes the tick at its own edge
        repeat (10) stepCycle();
        checkOutput("idle_mtime", acl0.mtime, 64'd10);
        applyStimulus(0, 16'hBFF8, 1'b0, 64'd0, 8'h00, r);
        checkOutput("rd_mtime", r, 64'd10);
        checkOutput("mtime_after_rd", acl0.mtime, 64'd11);
        checkOutput("idle_mtip", 64'(acl0.mtip), 64'd0);
        checkOutput("ready_busy", 64'(req_ready[0]), 64'd0);

        // Compare match: mtip rises exactly when mtime reaches mtimecmp
        applyStimulus(0, 16'h4000, 1'b1, 64'h20, 8'hFF, r);
        n = 0;
        while (acl0.mtime < 64'h1F && n < 64) begin
            stepCycle();
            n++;
        end
        checkOutput("mtime_at_1f", acl0.mtime, 64'h1F);
        checkOutput("mtip_below", 64'(acl0.mtip), 64'd0);
        stepCycle();
        checkOutput("mtime_at_20", acl0.mtime, 64'h20);
        checkOutput("mtip_equal", 64'(acl0.mtip), 64'd1);
        applyStimulus(0, 16'h4000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
        checkOutput("mtip_cmp_max", 64'(acl0.mtip), 64'd0);

        // MSIP: only lane 0 bit 0 is stored
        applyStimulus(0, 16'h0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, r);
        checkOutput("msip_set", 64'(acl0.msip), 64'd1);
        applyStimulus(0, 16'h0000, 1'b0, 64'd0, 8'h00, r);
        checkOutput("rd_msip", r, 64'd1);
        applyStimulus(0, 16'h0000, 1'b1, 64'd0, 8'h01, r);
        checkOutput("msip_clr", 64'(acl0.msip), 64'd0);
        applyStimulus(0, 16'h0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFE, r);
        checkOutput("msip_lane_masked", 64'(acl0.msip), 64'd0);

        // Wrap of mtime clears mtip
        applyStimulus(0, 16'h4000, 1'b1, 64'h10, 8'hFF, r);
        checkOutput("mtip_cmp_10", 64'(acl0.mtip), 64'd1);
        applyStimulus(0, 16'hBFF8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, r);
        checkOutput("mtime_wr_fe", acl0.mtime, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("mtip_pre_wrap", 64'(acl0.mtip), 64'd1);
        stepCycle();
        checkOutput("mtime_ff", acl0.mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        stepCycle();
        checkOutput("mtime_wrap", acl0.mtime, 64'd0);
        checkOutput("mtip_wrap", 64'(acl0.mtip), 64'd0);

        // Back-to-back requests alternate ready; unmapped offset reads 0
        stepCycle();
        req_valid[0] = 1'b1;
        req_addr[0]  = 16'h1234;
        req_wen[0]   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("b2b_ready", 64'(req_ready[0]), 64'((i % 2) == 0));
            checkOutput("b2b_resp", 64'(resp_valid[0]), 64'((i % 2) == 1));
            if (i % 2 == 1) checkOutput("rd_unmapped", resp_rdata[0], 64'd0);
            stepCycle();
        end
        req_valid[0] = 1'b0;
        applyStimulus(0, 16'h1234, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
        checkOutput("unmapped_msip", 64'(acl0.msip), 64'd0);
        applyStimulus(0, 16'h4000, 1'b0, 64'd0, 8'h00, r);
        checkOutput("unmapped_cmp", r, 64'h10);

        // Reset asserted while the response is on the bus
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_resp_valid", 64'(resp_valid[0]), 64'd0);
        checkOutput("midrst_resp_rdata", resp_rdata[0], 64'd0);
        checkOutput("midrst_mtime", acl0.mtime, 64'd0);
        checkOutput("midrst_mtip", 64'(acl0.mtip), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // PRESCALE=4: MTIME write on a tick edge wins and restarts the period
        prev = acl1.mtime;
        n = 0;
        while (acl1.mtime == prev && n < 8) begin
            stepCycle();
            n++;
        end
        checkOutput("ps4_tick_seen", 64'(acl1.mtime != prev), 64'd1);
        prev = acl1.mtime;
        repeat (3) stepCycle();
        checkOutput("ps4_hold", acl1.mtime, prev);
        applyStimulus(1, 16'hBFF8, 1'b1, 64'h100, 8'hFF, r);
        checkOutput("ps4_wr_wins", acl1.mtime, 64'h100);
        repeat (3) stepCycle();
        checkOutput("ps4_no_early", acl1.mtime, 64'h100);
        stepCycle();
        checkOutput("ps4_next_tick", acl1.mtime, 64'h101);
        applyStimulus(1, 16'hBFF8, 1'b1, 64'hFFFF_FFFF_FFFF_FFAA, 8'h01, r);
        checkOutput("ps4_partial", acl1.mtime, 64'h1AA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
